pwm_peripheral: RTL
===================

PWM_PERIPHERAL -- requirements
Module: pwm_peripheral

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 13, giving the clk cycles per PWM step, legal range 1..65535.
REQ-002 Port clk  input  1  system clock; all logic SHALL be on its rising edge.
REQ-003 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port en_reg_out  input  16  per-channel output enable, from the SPI register file.
REQ-005 Port en_reg_pwm  input  16  per-channel PWM mode select, from the SPI register file.
REQ-006 Port pwm_duty_cycle  input  8  shared duty value, from the SPI register file.
REQ-007 Port out  output  16  channel outputs; bits 7:0 drive uo_out, bits 15:8 drive uio_out.
REQ-008 Port period_start  output  1  single-cycle pulse marking step 0 of each PWM period.

Function
REQ-009 A prescaler SHALL count 0..CLK_DIV-1 and assert a one-cycle tick when at CLK_DIV-1, then wrap to 0.
REQ-010 An 8-bit step counter SHALL advance by 1 on each tick, wrapping 255->0, for a period of 256*CLK_DIV clk cycles.
REQ-011 The FSM SHALL have two states: IDLE and RUN.
REQ-012 IDLE->RUN SHALL occur when (en_reg_out & en_reg_pwm) != 0; RUN->IDLE SHALL occur on the first cycle that the expression is 0.
REQ-013 In IDLE, the prescaler and step counter SHALL be held at 0, and period_start SHALL be 0.
REQ-014 On the IDLE->RUN transition, duty_shadow SHALL load pwm_duty_cycle, and the counters SHALL start from 0.
REQ-015 In RUN, duty_shadow SHALL reload from pwm_duty_cycle only on the tick where the step counter wraps 255->0; mid-period input changes SHALL NOT affect the current period.
REQ-016 The PWM signal SHALL be 1 when step < duty_shadow. When duty_shadow = 8'hFF it SHALL be constantly 1. When duty_shadow = 0 it SHALL be constantly 0.
REQ-017 The next value of out[i] SHALL be 0 if en_reg_out[i]=0; 1 if en_reg_out[i]=1 and en_reg_pwm[i]=0; otherwise the PWM signal.
REQ-018 out SHALL be registered, with exactly 1 clk of latency from an enable change or from the step/duty state to the out pin.
REQ-019 period_start SHALL be registered, and SHALL be high for 1 clk when step=0 and the prescaler=0 in RUN, including the first cycle after entering RUN.
REQ-020 Every RUN channel SHALL share one counter, so all PWM edges across channels are phase-aligned.
REQ-021 Simultaneous wrap and RUN->IDLE: IDLE SHALL win, and the counters SHALL clear.

Reset
REQ-022 While rst_n=0, the following SHALL be forced: out=16'h0000, period_start=0, state=IDLE, prescaler=0, step=0, duty_shadow=8'h00.
REQ-023 Reset asserted mid-period SHALL abort the period immediately and asynchronously. After release, operation SHALL resume per REQ-012 on the first clk edge.

Structure
REQ-024 Shared package pwm_pkg SHALL hold:
- PWM_STEPS=256
- DUTY_FULL=8'hFF
- the FSM state enum {IDLE, RUN}
REQ-025 The prescaler SHALL be a sub-module pwm_prescaler (parameter CLK_DIV; inputs clk, rst_n, clear; output tick). The rest SHALL be in pwm_peripheral.
REQ-026 The inputs SHALL be treated as synchronous to clk; the block SHALL add no synchronisers.

Verification
REQ-027 Scenario: en_reg_out=16'h0001, en_reg_pwm=0. Required: out=16'h0001 one clk later; period_start stays 0.
REQ-028 Scenario: en_reg_out=en_reg_pwm=16'h0001, duty=8'h80, CLK_DIV=13. Required:
- out[0] high 1664 clk and low 1664 clk per 3328-clk period;
- period_start pulses every 3328 clk.
REQ-029 Scenario: duty=8'h00, then 8'hFF, each channel-0 PWM for 2 periods. Required: out[0] constantly 0, then constantly 1, with no glitch at wrap.
REQ-030 Scenario: duty changed 8'h40->8'hC0 at step 100. Required: the current period keeps a 64-step high; the next period shows a 192-step high.
REQ-031 Scenario: en_reg_out=16'hFFFF, en_reg_pwm=16'hAAAA, duty=8'h40. Required:
- even bits constantly 1;
- odd bits PWM, all edges in the same cycle.
REQ-032 Scenario: rst_n pulsed low at step 150. Required:
- out=0 asynchronously;
- after release, period_start occurs on the first RUN cycle and step restarts at 0.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM peripheral.
//   PWM_STEPS : steps per PWM period (step counter range 0..PWM_STEPS-1)
//   DUTY_FULL : duty value that forces the PWM signal constantly high
//   STEP_W    : width of the step counter
//   pwm_state_e : controller FSM states
package pwm_pkg;

    localparam int unsigned PWM_STEPS = 256;
    localparam logic [7:0]  DUTY_FULL = 8'hFF;
    localparam int unsigned STEP_W    = $clog2(PWM_STEPS);

    typedef enum logic {
        IDLE,
        RUN
    } pwm_state_e;

endpackage

// File: rtl/pwm_prescaler.sv
// Clock prescaler: counts 0..CLK_DIV-1 and flags the last count with a tick.
//   clk   : system clock (rising edge)
//   rst_n : asynchronous active-low reset
//   clear : holds the count at 0 and suppresses tick
//   tick  : high for the one cycle the count sits at CLK_DIV-1
module pwm_prescaler #(
    parameter int unsigned CLK_DIV = 13
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic tick
);

    localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        tick  = !clear && (cnt_q == CNT_MAX);
        cnt_d = cnt_q;
        if (clear || (cnt_q == CNT_MAX)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/pwm_peripheral.sv
// 16-channel PWM peripheral with one shared, phase-aligned period counter.
//   clk            : system clock (rising edge)
//   rst_n          : asynchronous active-low reset
//   en_reg_out     : per-channel output enable
//   en_reg_pwm     : per-channel PWM mode (0 = static high when enabled)
//   pwm_duty_cycle : shared duty, sampled at period boundaries only
//   out            : registered channel outputs
//   period_start   : registered one-cycle pulse at step 0 of each period
module pwm_peripheral
    import pwm_pkg::*;
#(
    parameter int unsigned CLK_DIV = 13
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] en_reg_out,
    input  logic [15:0] en_reg_pwm,
    input  logic [7:0]  pwm_duty_cycle,
    output logic [15:0] out,
    output logic        period_start
);

    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(PWM_STEPS - 1);

    pwm_state_e        state_q, state_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic [7:0]        duty_q, duty_d;
    // Mirrors "prescaler count == 0" without exporting the count.
    logic              presc_zero_q, presc_zero_d;
    logic [15:0]       out_q, out_d;
    logic              period_start_q, period_start_d;

    logic any_pwm;
    logic run_now;
    logic tick;
    logic pwm_level;

    assign any_pwm = |(en_reg_out & en_reg_pwm);
    // Leaving RUN this cycle counts as not running, so exit beats a wrap.
    assign run_now = (state_q == RUN) && any_pwm;

    pwm_prescaler #(
        .CLK_DIV (CLK_DIV)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (!run_now),
        .tick  (tick)
    );

    always_comb begin
        state_d      = state_q;
        step_d       = step_q;
        duty_d       = duty_q;
        presc_zero_d = presc_zero_q;
        unique case (state_q)
            IDLE: begin
                step_d       = '0;
                presc_zero_d = 1'b1;
                if (any_pwm) begin
                    state_d = RUN;
                    duty_d  = pwm_duty_cycle;
                end
            end
            RUN: begin
                if (!any_pwm) begin
                    state_d      = IDLE;
                    step_d       = '0;
                    presc_zero_d = 1'b1;
                end else begin
                    presc_zero_d = tick;
                    if (tick) begin
                        step_d = step_q + 1'b1;
                        if (step_q == STEP_LAST) begin
                            duty_d = pwm_duty_cycle;
                        end
                    end
                end
            end
        endcase
    end

    always_comb begin
        pwm_level = (state_q == RUN) && ((duty_q == DUTY_FULL) || (step_q < duty_q));
        out_d          = en_reg_out & (~en_reg_pwm | {16{pwm_level}});
        period_start_d = run_now && (step_q == '0) && presc_zero_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            step_q         <= '0;
            duty_q         <= 8'h00;
            presc_zero_q   <= 1'b1;
            out_q          <= 16'h0000;
            period_start_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            step_q         <= step_d;
            duty_q         <= duty_d;
            presc_zero_q   <= presc_zero_d;
            out_q          <= out_d;
            period_start_q <= period_start_d;
        end
    end

    assign out          = out_q;
    assign period_start = period_start_q;

endmodule
